// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between two byte requesters, the shared arbiter and its downstream consumer.
// master = arbiter side, slave = requesters plus consumer.
interface mux_rr_arbiter_if;
  logic       req_0;
  logic       req_1;
  logic [7:0] data_0;
  logic [7:0] data_1;
  logic       out_ready;
  logic       gnt_0;
  logic       gnt_1;
  logic       sel;
  logic [7:0] out_data;
  logic       out_valid;
  logic       stall;
  logic [7:0] xfer_cnt;

  modport master (
    input  req_0, req_1, data_0, data_1, out_ready,
    output gnt_0, gnt_1, sel, out_data, out_valid, stall, xfer_cnt
  );

  modport slave (
    output req_0, req_1, data_0, data_1, out_ready,
    input  gnt_0, gnt_1, sel, out_data, out_valid, stall, xfer_cnt
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-channel round-robin arbiter feeding one 8-bit 2:1 mux and a single holding register,
// with a valid/ready output, a stall flag and a completed-transfer counter.
module mux_rr_arbiter #(
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.master  bus
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  state_t     state;
  logic       last;
  logic [7:0] stall_cnt;
  logic       can_grant;
  logic       grant;
  logic       win;
  logic       done;

  assign can_grant = (state == IDLE) || bus.out_ready;
  assign done      = (state == XFER) && bus.out_ready;

  // NOTE: every always_comb output gets a default first, otherwise an unassigned path infers a latch.
  always_comb begin
    grant = 1'b0;
    win   = last;
    if (can_grant) begin
      if (bus.req_0 && bus.req_1) begin
        grant = 1'b1;
        win   = ~last;
      end else if (bus.req_0) begin
        grant = 1'b1;
        win   = 1'b0;
      end else if (bus.req_1) begin
        grant = 1'b1;
        win   = 1'b1;
      end
    end
  end

  // With no grant win stays at last, so SEL parks on the previous winner.
  assign bus.sel   = win;
  assign bus.gnt_0 = grant & ~win;
  assign bus.gnt_1 = grant &  win;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last          <= 1'b1;
      bus.out_data  <= 8'h00;
      bus.out_valid <= 1'b0;
      bus.stall     <= 1'b0;
      bus.xfer_cnt  <= 8'h00;
      stall_cnt     <= 8'h00;
    end else begin
      if (done) begin
        bus.xfer_cnt <= bus.xfer_cnt + 8'd1;
      end

      if (grant) begin
        bus.out_data  <= win ? bus.data_1 : bus.data_0;
        last          <= win;
        state         <= XFER;
        bus.out_valid <= 1'b1;
      end else if (done) begin
        state         <= IDLE;
        bus.out_valid <= 1'b0;
      end

      // Stall counter only runs while a byte is waiting on a stalled consumer.
      if ((state == XFER) && !bus.out_ready) begin
        if (stall_cnt != LIMIT) begin
          stall_cnt <= stall_cnt + 8'd1;
          bus.stall <= ((stall_cnt + 8'd1) == LIMIT);
        end
      end else begin
        stall_cnt <= 8'h00;
        bus.stall <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: grant timing, round-robin ties, stall flag,
// blocked grants, asynchronous reset and transfer-counter wrap.
module tb_mux_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mux_rr_arbiter_if bus_if ();

  mux_rr_arbiter #(.STALL_LIMIT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.req_0     = 1'b0;
    bus_if.req_1     = 1'b0;
    bus_if.data_0    = 8'h00;
    bus_if.data_1    = 8'h00;
    bus_if.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Reset state
    check("rst_valid", bus_if.out_valid, 1'b0);
    check("rst_data", bus_if.out_data, 8'h00);
    check("rst_cnt", bus_if.xfer_cnt, 8'h00);
    check("rst_stall", bus_if.stall, 1'b0);
    check("rst_sel_parked", bus_if.sel, 1'b1);

    // Single transfer on channel 0
    bus_if.req_0 = 1'b1; bus_if.data_0 = 8'hA5; bus_if.out_ready = 1'b1;
    settle();
    check("t1_gnt0", bus_if.gnt_0, 1'b1);
    check("t1_gnt1", bus_if.gnt_1, 1'b0);
    check("t1_sel", bus_if.sel, 1'b0);
    tick();
    bus_if.req_0 = 1'b0;
    settle();
    check("t1_gnt0_drop", bus_if.gnt_0, 1'b0);
    check("t1_data", bus_if.out_data, 8'hA5);
    check("t1_valid", bus_if.out_valid, 1'b1);
    check("t1_cnt_before", bus_if.xfer_cnt, 8'd0);
    tick();
    settle();
    check("t1_valid_fall", bus_if.out_valid, 1'b0);
    check("t1_cnt_after", bus_if.xfer_cnt, 8'd1);
    check("t1_sel_hold", bus_if.sel, 1'b0);

    // Round robin with both requests held, starting from reset
    do_reset();
    bus_if.req_0 = 1'b1; bus_if.req_1 = 1'b1;
    bus_if.data_0 = 8'h11; bus_if.data_1 = 8'h22; bus_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("rr_gnt0_%0d", i), bus_if.gnt_0, (i % 2) == 0);
      check($sformatf("rr_gnt1_%0d", i), bus_if.gnt_1, (i % 2) == 1);
      tick();
      check($sformatf("rr_data_%0d", i), bus_if.out_data, ((i % 2) == 0) ? 8'h11 : 8'h22);
      check($sformatf("rr_valid_%0d", i), bus_if.out_valid, 1'b1);
    end
    bus_if.req_0 = 1'b0; bus_if.req_1 = 1'b0;
    tick();
    settle();
    check("rr_idle", bus_if.out_valid, 1'b0);
    check("rr_cnt", bus_if.xfer_cnt, 8'd4);

    // Stall on channel 1
    bus_if.req_1 = 1'b1; bus_if.data_1 = 8'h3C; bus_if.out_ready = 1'b0;
    settle();
    check("st_gnt1", bus_if.gnt_1, 1'b1);
    tick();
    bus_if.req_1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("st_stall_%0d", k), bus_if.stall, k >= 16);
      check($sformatf("st_data_%0d", k), bus_if.out_data, 8'h3C);
    end
    bus_if.out_ready = 1'b1;
    tick();
    settle();
    check("st_stall_clear", bus_if.stall, 1'b0);
    check("st_idle", bus_if.out_valid, 1'b0);
    check("st_cnt", bus_if.xfer_cnt, 8'd5);

    // Grant blocked while downstream is not ready
    bus_if.out_ready = 1'b0;
    bus_if.req_1 = 1'b1; bus_if.data_1 = 8'h44;
    tick();
    bus_if.req_1 = 1'b0;
    bus_if.req_0 = 1'b1; bus_if.data_0 = 8'h55;
    settle();
    check("blk_gnt0_a", bus_if.gnt_0, 1'b0);
    tick();
    check("blk_gnt0_b", bus_if.gnt_0, 1'b0);
    check("blk_data_held", bus_if.out_data, 8'h44);
    bus_if.out_ready = 1'b1;
    settle();
    check("blk_gnt0_go", bus_if.gnt_0, 1'b1);
    tick();
    bus_if.req_0 = 1'b0;
    check("blk_data_new", bus_if.out_data, 8'h55);
    check("blk_no_gap", bus_if.out_valid, 1'b1);
    tick();

    // Asynchronous reset in the middle of a transfer
    bus_if.out_ready = 1'b0;
    bus_if.req_0 = 1'b1; bus_if.data_0 = 8'h7E;
    tick();
    bus_if.req_0 = 1'b0;
    check("ar_data_pre", bus_if.out_data, 8'h7E);
    check("ar_cnt_pre", bus_if.xfer_cnt, 8'd7);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", bus_if.out_valid, 1'b0);
    check("ar_data", bus_if.out_data, 8'h00);
    check("ar_stall", bus_if.stall, 1'b0);
    check("ar_cnt", bus_if.xfer_cnt, 8'h00);
    tick();
    rst = 1'b0;
    bus_if.req_0 = 1'b1; bus_if.req_1 = 1'b1;
    bus_if.data_0 = 8'h11; bus_if.data_1 = 8'h22; bus_if.out_ready = 1'b1;
    settle();
    check("ar_tie_gnt0", bus_if.gnt_0, 1'b1);
    check("ar_tie_gnt1", bus_if.gnt_1, 1'b0);
    tick();
    bus_if.req_0 = 1'b0; bus_if.req_1 = 1'b0;
    check("ar_tie_data", bus_if.out_data, 8'h11);
    tick();

    // Transfer counter wrap
    do_reset();
    bus_if.req_0 = 1'b1; bus_if.data_0 = 8'h5A; bus_if.out_ready = 1'b1;
    for (int n = 0; n < 256; n++) tick();
    check("wr_cnt_255", bus_if.xfer_cnt, 8'd255);
    tick();
    check("wr_cnt_wrap", bus_if.xfer_cnt, 8'd0);
    bus_if.req_0 = 1'b0;
    tick();
    check("wr_cnt_257", bus_if.xfer_cnt, 8'd1);
    check("wr_idle", bus_if.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
